// File: rtl/pipeline_pkg.sv
// Shared types and constants for the 5-stage core pipeline control.
// Contents: controller state encoding, register address width, and the
// all-zero control word loaded into a pipeline register when it is flushed.
package pipeline_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MC_WAIT    = 2'd2
    } ctrl_state_t;

    // Control fields carried by each pipeline register; a bubble clears both
    // architectural side effects.
    typedef struct packed {
        logic reg_wr_en;
        logic ram_wr_en;
    } stage_ctrl_t;

    localparam stage_ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator.
// Ports:
//   id_rs1_address/id_rs2_address  source registers of the instruction in ID
//   id_rs1_used/id_rs2_used        ID instruction actually reads that source
//   ex_rd_address                  destination of the instruction in EX
//   ex_is_load                     EX instruction is a register-writing load
//   load_use_c                     ID must wait for the load result
module hazard_detect
    import pipeline_pkg::*;
#(
    parameter int unsigned ADDR_W = REG_ADDR_W
) (
    input  logic [ADDR_W-1:0] id_rs1_address,
    input  logic [ADDR_W-1:0] id_rs2_address,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [ADDR_W-1:0] ex_rd_address,
    input  logic              ex_is_load,
    output logic              load_use_c
);

    logic rs1_match_c;
    logic rs2_match_c;

    assign rs1_match_c = id_rs1_used && (id_rs1_address == ex_rd_address);
    assign rs2_match_c = id_rs2_used && (id_rs2_address == ex_rd_address);

    // x0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign load_use_c = ex_is_load && (ex_rd_address != '0) && (rs1_match_c || rs2_match_c);

endmodule

// File: rtl/pipeline_controller.sv
// Stall/flush sequencer for the 5-stage core.
// Ports:
//   clk, reset_n                   clock, asynchronous active-low reset
//   id_*, ex_rd_address, ex_is_load  load-use hazard inputs
//   ex_redirect                    taken branch/jump resolved in EX
//   mc_start, mc_done              multi-cycle unit handshake in EX
//   stall_cnt_clr                  synchronous clear of stall_cycles
//   *_wr_en                        PC and pipeline register write enables
//   *_flush                        load a bubble instead of the stage input
//   ctrl_state                     current FSM state (debug)
//   stall_cycles                   saturating count of cycles with PC held
module pipeline_controller
    import pipeline_pkg::*;
#(
    parameter int unsigned REG_ADDR_W        = pipeline_pkg::REG_ADDR_W,
    parameter int unsigned LOAD_STALL_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] id_rs1_address,
    input  logic [REG_ADDR_W-1:0] id_rs2_address,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] ex_rd_address,
    input  logic                  ex_is_load,
    input  logic                  ex_redirect,
    input  logic                  mc_start,
    input  logic                  mc_done,
    input  logic                  stall_cnt_clr,
    output logic                  pc_wr_en,
    output logic                  if_id_wr_en,
    output logic                  id_ex_wr_en,
    output logic                  ex_mem_wr_en,
    output logic                  mem_wb_wr_en,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  ex_mem_flush,
    output logic [1:0]            ctrl_state,
    output logic [31:0]           stall_cycles
);

    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] LOAD_CNT_INIT = CNT_W'(LOAD_STALL_CYCLES - 1);

    ctrl_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      stall_cycles_q, stall_cycles_d;
    logic             load_use_c;
    logic             mc_hold_c;

    hazard_detect #(
        .ADDR_W (REG_ADDR_W)
    ) u_hazard_detect (
        .id_rs1_address (id_rs1_address),
        .id_rs2_address (id_rs2_address),
        .id_rs1_used    (id_rs1_used),
        .id_rs2_used    (id_rs2_used),
        .ex_rd_address  (ex_rd_address),
        .ex_is_load     (ex_is_load),
        .load_use_c     (load_use_c)
    );

    assign mc_hold_c = mc_start && !mc_done;

    // State, load-stall countdown and performance counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= RUN;
            cnt_q          <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    // Next-state, countdown and counter update.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        stall_cycles_d = stall_cycles_q;

        case (state_q)
            RUN: begin
                if (mc_hold_c) begin
                    state_d = MC_WAIT;
                end else if (ex_redirect) begin
                    state_d = RUN;
                end else if (load_use_c) begin
                    // The first stall cycle is spent here in RUN.
                    cnt_d = LOAD_CNT_INIT;
                    if (LOAD_CNT_INIT != '0) begin
                        state_d = LOAD_STALL;
                    end
                end
            end
            LOAD_STALL: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = RUN;
                end
            end
            MC_WAIT: begin
                if (mc_done) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (stall_cnt_clr) begin
            stall_cycles_d = '0;
        end else if (!pc_wr_en && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    // Enable/flush decode; everything frozen while reset is held.
    always_comb begin
        pc_wr_en     = 1'b1;
        if_id_wr_en  = 1'b1;
        id_ex_wr_en  = 1'b1;
        ex_mem_wr_en = 1'b1;
        mem_wb_wr_en = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;

        if (!reset_n) begin
            pc_wr_en     = 1'b0;
            if_id_wr_en  = 1'b0;
            id_ex_wr_en  = 1'b0;
            ex_mem_wr_en = 1'b0;
            mem_wb_wr_en = 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (mc_hold_c) begin
                        pc_wr_en     = 1'b0;
                        if_id_wr_en  = 1'b0;
                        id_ex_wr_en  = 1'b0;
                        ex_mem_flush = 1'b1;
                    end else if (ex_redirect) begin
                        // Wrong-path instructions in IF/ID and ID/EX are squashed.
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (load_use_c) begin
                        pc_wr_en    = 1'b0;
                        if_id_wr_en = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
                LOAD_STALL: begin
                    pc_wr_en    = 1'b0;
                    if_id_wr_en = 1'b0;
                    id_ex_flush = 1'b1;
                end
                MC_WAIT: begin
                    if (!mc_done) begin
                        pc_wr_en     = 1'b0;
                        if_id_wr_en  = 1'b0;
                        id_ex_wr_en  = 1'b0;
                        ex_mem_flush = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ctrl_state   = state_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Scoreboard bench: two controllers (3-cycle and 1-cycle load stall) share
// the same stimulus; each cycle the driver queues the hand-derived response
// of both, and a monitor on the falling edge pops and compares.
module tb_pipeline_controller;

    localparam logic [4:0] W_ALL  = 5'b11111;
    localparam logic [4:0] W_NONE = 5'b00000;
    localparam logic [4:0] W_LS   = 5'b00111;
    localparam logic [4:0] W_MC   = 5'b00011;
    localparam logic [2:0] F_NONE = 3'b000;
    localparam logic [2:0] F_LS   = 3'b010;
    localparam logic [2:0] F_MC   = 3'b001;
    localparam logic [2:0] F_RD   = 3'b110;
    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_LS   = 2'd1;
    localparam logic [1:0] S_MC   = 2'd2;

    logic       clk;
    logic       reset_n;
    logic [4:0] id_rs1_address, id_rs2_address, ex_rd_address;
    logic       id_rs1_used, id_rs2_used, ex_is_load, ex_redirect;
    logic       mc_start, mc_done, stall_cnt_clr;

    logic        a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_fifid, a_fidex, a_fexmem;
    logic [1:0]  a_state;
    logic [31:0] a_sc;
    logic        b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_fifid, b_fidex, b_fexmem;
    logic [1:0]  b_state;
    logic [31:0] b_sc;

    logic [41:0] obs_a, obs_b;

    typedef struct {
        string       name;
        logic [41:0] a;
        logic [41:0] b;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;

    pipeline_controller #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(3)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .id_rs1_address(id_rs1_address), .id_rs2_address(id_rs2_address),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd_address(ex_rd_address), .ex_is_load(ex_is_load),
        .ex_redirect(ex_redirect), .mc_start(mc_start), .mc_done(mc_done),
        .stall_cnt_clr(stall_cnt_clr),
        .pc_wr_en(a_pc), .if_id_wr_en(a_ifid), .id_ex_wr_en(a_idex),
        .ex_mem_wr_en(a_exmem), .mem_wb_wr_en(a_memwb),
        .if_id_flush(a_fifid), .id_ex_flush(a_fidex), .ex_mem_flush(a_fexmem),
        .ctrl_state(a_state), .stall_cycles(a_sc)
    );

    pipeline_controller #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(1)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .id_rs1_address(id_rs1_address), .id_rs2_address(id_rs2_address),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd_address(ex_rd_address), .ex_is_load(ex_is_load),
        .ex_redirect(ex_redirect), .mc_start(mc_start), .mc_done(mc_done),
        .stall_cnt_clr(stall_cnt_clr),
        .pc_wr_en(b_pc), .if_id_wr_en(b_ifid), .id_ex_wr_en(b_idex),
        .ex_mem_wr_en(b_exmem), .mem_wb_wr_en(b_memwb),
        .if_id_flush(b_fifid), .id_ex_flush(b_fidex), .ex_mem_flush(b_fexmem),
        .ctrl_state(b_state), .stall_cycles(b_sc)
    );

    assign obs_a = {a_pc, a_ifid, a_idex, a_exmem, a_memwb, a_fifid, a_fidex, a_fexmem, a_state, a_sc};
    assign obs_b = {b_pc, b_ifid, b_idex, b_exmem, b_memwb, b_fifid, b_fidex, b_fexmem, b_state, b_sc};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic string fmt(input logic [41:0] v);
        return $sformatf("wr=%b fl=%b st=%0d sc=%h", v[41:37], v[36:34], v[33:32], v[31:0]);
    endfunction

    // Monitor: one expected entry per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            cur = sb_q.pop_front();
            checks++;
            if (obs_a !== cur.a) begin
                errors++;
                $display("FAIL %s L3: got %s expected %s", cur.name, fmt(obs_a), fmt(cur.a));
            end
            checks++;
            if (obs_b !== cur.b) begin
                errors++;
                $display("FAIL %s L1: got %s expected %s", cur.name, fmt(obs_b), fmt(cur.b));
            end
        end
    end

    task automatic push(input string n,
                        input logic [4:0] wa, input logic [2:0] fa, input logic [1:0] sa, input logic [31:0] ca,
                        input logic [4:0] wb, input logic [2:0] fb, input logic [1:0] sb, input logic [31:0] cb);
        exp_t e;
        e.name = n;
        e.a    = {wa, fa, sa, ca};
        e.b    = {wb, fb, sb, cb};
        sb_q.push_back(e);
    endtask

    task automatic push2(input string n, input logic [4:0] w, input logic [2:0] f,
                         input logic [1:0] s, input logic [31:0] ca, input logic [31:0] cb);
        push(n, w, f, s, ca, w, f, s, cb);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1_address = '0; id_rs2_address = '0; ex_rd_address = '0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_is_load = 1'b0;
        ex_redirect = 1'b0; mc_start = 1'b0; mc_done = 1'b0; stall_cnt_clr = 1'b0;
    endtask

    task automatic set_ld(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2);
        idle();
        ex_rd_address = rd; id_rs1_address = rs1; id_rs2_address = rs2;
        id_rs1_used = u1; id_rs2_used = u2; ex_is_load = 1'b1;
    endtask

    initial begin
        idle();
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        push2("reset", W_NONE, F_NONE, S_RUN, 0, 0); tick();
        reset_n = 1'b1;
        push2("post_reset", W_ALL, F_NONE, S_RUN, 0, 0); tick();

        // Load-use on rs1 (x5)
        set_ld(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
        push2("load_use_rs1", W_LS, F_LS, S_RUN, 0, 0); tick();
        idle();
        push("ls_cycle2", W_LS, F_LS, S_LS, 1, W_ALL, F_NONE, S_RUN, 1); tick();
        push("ls_cycle3", W_LS, F_LS, S_LS, 2, W_ALL, F_NONE, S_RUN, 1); tick();
        push2("ls_done", W_ALL, F_NONE, S_RUN, 3, 1); tick();

        // No hazard cases
        set_ld(5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
        push2("rd_zero", W_ALL, F_NONE, S_RUN, 3, 1); tick();
        set_ld(5'd9, 5'd9, 5'd3, 1'b0, 1'b1);
        push2("rs1_unused", W_ALL, F_NONE, S_RUN, 3, 1); tick();

        // Redirect beats a load-use match
        set_ld(5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
        ex_redirect = 1'b1;
        push2("redirect_hazard", W_ALL, F_RD, S_RUN, 3, 1); tick();

        // Multi-cycle op, done 4 cycles after start
        idle(); mc_start = 1'b1;
        push2("mc_start", W_MC, F_MC, S_RUN, 3, 1); tick();
        push2("mc_wait1", W_MC, F_MC, S_MC, 4, 2); tick();
        push2("mc_wait2", W_MC, F_MC, S_MC, 5, 3); tick();
        push2("mc_wait3", W_MC, F_MC, S_MC, 6, 4); tick();
        mc_done = 1'b1;
        push2("mc_done", W_ALL, F_NONE, S_MC, 7, 5); tick();
        push2("mc_single", W_ALL, F_NONE, S_RUN, 7, 5); tick();

        idle(); stall_cnt_clr = 1'b1;
        push2("clr", W_ALL, F_NONE, S_RUN, 7, 5); tick();
        idle();
        push2("clr_done", W_ALL, F_NONE, S_RUN, 0, 0); tick();

        // Reset two cycles into MC_WAIT
        mc_start = 1'b1;
        push2("mc_pre_rst", W_MC, F_MC, S_RUN, 0, 0); tick();
        push2("mc_rst_w1", W_MC, F_MC, S_MC, 1, 1); tick();
        push2("mc_rst_w2", W_MC, F_MC, S_MC, 2, 2); tick();
        reset_n = 1'b0;
        push2("rst_in_mc", W_NONE, F_NONE, S_RUN, 0, 0); tick();
        idle(); reset_n = 1'b1;
        push2("rst_mc_release", W_ALL, F_NONE, S_RUN, 0, 0); tick();

        // Saturation from a preloaded counter
        force dut_a.stall_cycles_q = 32'hFFFF_FFFE;
        force dut_b.stall_cycles_q = 32'hFFFF_FFFE;
        #1;
        release dut_a.stall_cycles_q;
        release dut_b.stall_cycles_q;
        mc_start = 1'b1;
        push2("sat_start", W_MC, F_MC, S_RUN, 32'hFFFF_FFFE, 32'hFFFF_FFFE); tick();
        push2("sat_w1", W_MC, F_MC, S_MC, 32'hFFFF_FFFF, 32'hFFFF_FFFF); tick();
        push2("sat_w2", W_MC, F_MC, S_MC, 32'hFFFF_FFFF, 32'hFFFF_FFFF); tick();
        mc_done = 1'b1;
        push2("sat_done", W_ALL, F_NONE, S_MC, 32'hFFFF_FFFF, 32'hFFFF_FFFF); tick();
        idle(); stall_cnt_clr = 1'b1;
        push2("sat_clr", W_ALL, F_NONE, S_RUN, 32'hFFFF_FFFF, 32'hFFFF_FFFF); tick();
        idle();
        push2("sat_cleared", W_ALL, F_NONE, S_RUN, 0, 0); tick();

        // Load-use on rs2, hazard held (ignored in LOAD_STALL), reset mid-stall
        set_ld(5'd6, 5'd1, 5'd6, 1'b0, 1'b1);
        push2("load_use_rs2", W_LS, F_LS, S_RUN, 0, 0); tick();
        push("ls_ignore", W_LS, F_LS, S_LS, 1, W_LS, F_LS, S_RUN, 1); tick();
        idle(); reset_n = 1'b0;
        push2("rst_in_ls", W_NONE, F_NONE, S_RUN, 0, 0); tick();
        reset_n = 1'b1;
        push2("rst_ls_release", W_ALL, F_NONE, S_RUN, 0, 0); tick();

        repeat (2) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d entries left expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_controller.md
# pipeline_controller

Central stall/flush sequencer for the 5-stage core. It drives the write enables and bubble-insert (flush) controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three hazard classes:

- load-use data hazards (fixed multi-cycle stall);
- control redirects resolved in EX;
- multi-cycle execution units that hold EX until done.

It also keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- `REG_ADDR_W`, 5, register address width.
- `LOAD_STALL_CYCLES`, 1, bubbles inserted on a load-use hazard; legal 1..7.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `id_rs1_address`  in  `REG_ADDR_W`  rs1 of the instruction in ID.
- `id_rs2_address`  in  `REG_ADDR_W`  rs2 of the instruction in ID.
- `id_rs1_used`  in  1  ID instruction reads rs1.
- `id_rs2_used`  in  1  ID instruction reads rs2.
- `ex_rd_address`  in  `REG_ADDR_W`  rd of the instruction in EX.
- `ex_is_load`  in  1  EX instruction is a register-writing load.
- `ex_redirect`  in  1  EX resolved a taken branch or jump; PC input mux already selects the target.
- `mc_start`  in  1  EX instruction uses a multi-cycle unit.
- `mc_done`  in  1  multi-cycle result valid this cycle.
- `stall_cnt_clr`  in  1  synchronous clear of `stall_cycles`.
- `pc_wr_en`, `if_id_wr_en`, `id_ex_wr_en`, `ex_mem_wr_en`, `mem_wb_wr_en`  out  1 each  register write enables.
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush`  out  1 each  load a bubble (all-zero control; `reg_wr_en`=`ram_wr_en`=0) instead of the input.
- `ctrl_state`  out  2  current FSM state, for debug.
- `stall_cycles`  out  32  count of cycles with `pc_wr_en`=0.

## Operation
- States: RUN, LOAD_STALL, MC_WAIT.
- Outputs are combinational from state and inputs; default is all `wr_en`=1, all flush=0.
- Load-use hazard: `ex_is_load` && `ex_rd_address`!=0 && ((`id_rs1_used` && rs1==rd) || (`id_rs2_used` && rs2==rd)).

RUN, priority highest first:
1. `mc_start` && !`mc_done`:
   - `pc_wr_en`, `if_id_wr_en`, `id_ex_wr_en` = 0; `ex_mem_flush` = 1.
   - Go to MC_WAIT.
2. `ex_redirect`:
   - `pc_wr_en` = 1; `if_id_flush` = `id_ex_flush` = 1.
   - Stay in RUN. Any load-use match is discarded because the ID instruction is wrong-path.
3. Load-use hazard:
   - `pc_wr_en` = `if_id_wr_en` = 0; `id_ex_flush` = 1.
   - Load the counter with `LOAD_STALL_CYCLES`-1.
   - If the result is 0 stay in RUN, otherwise go to LOAD_STALL.
4. `mc_start` && `mc_done` in the same cycle is a single-cycle op: no stall.

LOAD_STALL:
- Same outputs as a load-use stall.
- Decrement the counter; go to RUN when the counter is 0.
- Hazard inputs are ignored in this state.

MC_WAIT:
- Outputs as in RUN case 1 while !`mc_done`.
- On `mc_done`: all enables 1, no flush, go to RUN.
- `ex_redirect` and hazard inputs are ignored; EX must not assert them while held.

Counter:
- `stall_cycles` increments when `pc_wr_en`=0 and saturates at 0xFFFF_FFFF.
- `stall_cnt_clr` has priority over the increment.

## Timing
- Zero-cycle decision latency: enables and flushes react in the same cycle as their inputs.
- A load-use hazard stalls the PC for exactly `LOAD_STALL_CYCLES` cycles.
- A multi-cycle op with `mc_done` N cycles after `mc_start` stalls for N cycles.

Reset (`reset_n`=0, asynchronous):
- State RUN, stall counter 0, `stall_cycles`=0.
- All `wr_en`=0 and all flushes=0 while asserted; no pipeline register changes.
- Reset mid-MC_WAIT or mid-LOAD_STALL aborts to RUN immediately.
- The first edge after release behaves as RUN.

## Structure
- Shared package `pipeline_pkg` holds:
  - `ctrl_state_t` enum: RUN=0, LOAD_STALL=1, MC_WAIT=2;
  - `REG_ADDR_W`;
  - the bubble-encoding constant used by the top-level flush muxes.
- Sub-module `hazard_detect`: the combinational load-use comparator, reusable when forwarding is added.

## Test plan
- Load writes x5 in EX, ID add reads x5 with `LOAD_STALL_CYCLES`=1 -> one cycle `pc_wr_en`=0, `id_ex_flush`=1, `stall_cycles`=1.
- Same hazard with `LOAD_STALL_CYCLES`=3 -> 3 stall cycles via LOAD_STALL, then RUN. With `ex_rd_address`=0 instead -> no stall.
- `ex_redirect` together with a load-use match -> `if_id_flush`=`id_ex_flush`=1, `pc_wr_en`=1, no stall cycle counted.
- `mc_start` with `mc_done` 4 cycles later -> 4 cycles `ex_mem_flush`=1 and enables 0, then release; `stall_cycles`=4. `mc_done` in the same cycle -> 0 stalls.
- Assert `reset_n`=0 two cycles into MC_WAIT -> `ctrl_state`=RUN and `stall_cycles`=0 immediately, all `wr_en`=0 until release.
- Preload the counter near saturation by forcing 0xFFFF_FFFE, stall 3 cycles -> holds at 0xFFFF_FFFF; `stall_cnt_clr` -> 0 next cycle.
